note_sequencer: RTL and testbench

Plays a stored melody on the square-wave generator. A small note table holds (period, duration) pairs. On start, the sequencer walks the table and drives the generator's `frequency_control` input. It also gates the audio path during rests and inter-note gaps, and optionally loops. It sits between the host/config logic and one `square_wave` instance.

---
 rtl/note_sequencer_pkg.sv | 19 +
 rtl/note_sequencer_table.sv | 28 ++
 rtl/note_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_note_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared types and helpers for the note sequencer and its note table.
package note_sequencer_pkg;

    // Playback states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPlay,
        StGap,
        StAdvance
    } state_e;

    // Width of one note table entry: period in the upper bits, duration in the lower bits.
    function automatic int unsigned entry_width(input int unsigned counter_width,
                                                input int unsigned dur_width);
        return counter_width + dur_width;
    endfunction

endpackage

// File: rtl/note_sequencer_table.sv
// Note table: register file with synchronous write and combinational read.
module note_table #(
    parameter int unsigned AddrWidth  = 4,
    parameter int unsigned EntryWidth = 20
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [AddrWidth-1:0]  wr_addr_i,
    input  logic [EntryWidth-1:0] wr_data_i,
    input  logic [AddrWidth-1:0]  rd_addr_i,
    output logic [EntryWidth-1:0] rd_data_o
);

    logic [EntryWidth-1:0] mem_q [2**AddrWidth];

    // Table contents are not reset; the host loads them before playback.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read of the entry addressed by the sequencer.
    always_comb begin
        rd_data_o = mem_q[rd_addr_i];
    end

endmodule

// File: rtl/note_sequencer.sv
// Walks the note table and drives a square-wave generator's period and audio gate.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned counter_width = 8,
    parameter int unsigned dur_width     = 12,
    parameter int unsigned addr_width    = 4,
    parameter int unsigned tick_div      = 1000,
    parameter int unsigned gap_ticks     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [addr_width-1:0]    wr_addr,
    input  logic [counter_width-1:0] wr_period,
    input  logic [dur_width-1:0]     wr_duration,
    input  logic [addr_width:0]      length,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [counter_width-1:0] frequency_control,
    output logic                     note_gate,
    output logic [addr_width-1:0]    note_index,
    output logic                     note_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned EntryWidth = entry_width(counter_width, dur_width);
    localparam int unsigned LenWidth   = addr_width + 1;
    localparam int unsigned PrescWidth = $clog2(tick_div);
    localparam int unsigned GapWidth   = (gap_ticks > 0) ? $clog2(gap_ticks + 1) : 1;

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   idx_q, idx_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic [LenWidth-1:0]     skip_q, skip_d;
    logic                    loop_q, loop_d;
    logic [dur_width-1:0]    dur_q, dur_d;
    logic [GapWidth-1:0]     gap_q, gap_d;
    logic [PrescWidth-1:0]   presc_q, presc_d;
    logic [counter_width-1:0] freq_q, freq_d;
    logic                    gate_q, gate_d;
    logic                    strobe_q, strobe_d;
    logic                    done_q, done_d;

    logic [EntryWidth-1:0]    rd_entry;
    logic [counter_width-1:0] rd_period;
    logic [dur_width-1:0]     rd_duration;
    logic                     tick;
    logic                     last;
    logic                     finish;

    note_table #(
        .AddrWidth (addr_width),
        .EntryWidth(EntryWidth)
    ) u_note_table (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i({wr_period, wr_duration}),
        .rd_addr_i(idx_q),
        .rd_data_o(rd_entry)
    );

    // Entry decode, tick detection and last-entry detection.
    always_comb begin
        rd_period   = rd_entry[EntryWidth-1:dur_width];
        rd_duration = rd_entry[dur_width-1:0];
        tick        = (presc_q == PrescWidth'(tick_div - 1));
        last        = ({1'b0, idx_q} == len_q - LenWidth'(1));
    end

    // Next-state logic; stop overrides everything, including start and natural end.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        skip_d   = skip_q;
        loop_d   = loop_q;
        dur_d    = dur_q;
        gap_d    = gap_q;
        freq_d   = freq_q;
        gate_d   = gate_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        finish   = 1'b0;
        presc_d  = tick ? '0 : presc_q + PrescWidth'(1);

        unique case (state_q)
            StIdle: begin
                if (start && length != '0) begin
                    state_d = StLoad;
                    len_d   = length;
                    loop_d  = loop;
                    idx_d   = '0;
                    skip_d  = '0;
                    presc_d = '0;
                end
            end
            StLoad: begin
                if (rd_duration == '0) begin
                    // Skipped entry; a full lap of skips ends playback even when looping.
                    if ((skip_q + LenWidth'(1) == len_q) || (last && !loop_q)) begin
                        finish = 1'b1;
                    end else begin
                        skip_d = skip_q + LenWidth'(1);
                        idx_d  = last ? '0 : idx_q + addr_width'(1);
                    end
                end else begin
                    skip_d   = '0;
                    freq_d   = rd_period;
                    gate_d   = (rd_period != '0);
                    dur_d    = rd_duration;
                    strobe_d = 1'b1;
                    state_d  = StPlay;
                end
            end
            StPlay: begin
                if (tick) begin
                    dur_d = dur_q - dur_width'(1);
                    if (dur_q == dur_width'(1)) begin
                        if (gap_ticks > 0) begin
                            state_d = StGap;
                            gate_d  = 1'b0;
                            gap_d   = GapWidth'(gap_ticks);
                        end else begin
                            state_d = StAdvance;
                        end
                    end
                end
            end
            StGap: begin
                if (tick) begin
                    gap_d = gap_q - GapWidth'(1);
                    if (gap_q == GapWidth'(1)) begin
                        state_d = StAdvance;
                    end
                end
            end
            StAdvance: begin
                if (last && !loop_q) begin
                    finish = 1'b1;
                end else begin
                    idx_d   = last ? '0 : idx_q + addr_width'(1);
                    state_d = StLoad;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            state_d = StIdle;
            idx_d   = '0;
            freq_d  = '0;
            gate_d  = 1'b0;
            done_d  = 1'b1;
        end

        if (stop) begin
            state_d  = StIdle;
            idx_d    = '0;
            freq_d   = '0;
            gate_d   = 1'b0;
            strobe_d = 1'b0;
            done_d   = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            len_q    <= '0;
            skip_q   <= '0;
            loop_q   <= 1'b0;
            dur_q    <= '0;
            gap_q    <= '0;
            presc_q  <= '0;
            freq_q   <= '0;
            gate_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            skip_q   <= skip_d;
            loop_q   <= loop_d;
            dur_q    <= dur_d;
            gap_q    <= gap_d;
            presc_q  <= presc_d;
            freq_q   <= freq_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        frequency_control = freq_q;
        note_gate         = gate_q;
        note_index        = idx_q;
        note_strobe       = strobe_q;
        busy              = (state_q != StIdle);
        done              = done_q;
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench: two sequencers (gap 0 and gap 2) share stimulus; each is checked every cycle
// against a timeline model, plus hand-derived strobe/done counts per scenario.
module tb_note_sequencer;

    localparam int TD   = 4;
    localparam int MaxE = 256;

    typedef struct packed {
        logic [7:0] freq;
        logic       gate;
        logic [3:0] idx;
        logic       strobe;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        int tab;
        int len;
        bit lp;
        int stop_e;
        int xstart;
        int n;
        int s0;
        int d0;
        int s2;
        int d2;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_period = '0;
    logic [11:0] wr_duration = '0;
    logic [4:0]  length = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic [7:0] freq0, freq2;
    logic       gate0, gate2, strobe0, strobe2, busy0, busy2, done0, done2;
    logic [3:0] idx0, idx2;

    int   n_tests = 0;
    int   n_fail = 0;
    int   tb_per [16];
    int   tb_dur [16];
    out_t mdl  [MaxE];
    out_t exp0 [MaxE];
    out_t exp2 [MaxE];

    always #5 clk = ~clk;

    note_sequencer #(
        .counter_width(8), .dur_width(12), .addr_width(4), .tick_div(TD), .gap_ticks(0)
    ) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
        .wr_duration(wr_duration), .length(length), .loop(loop), .start(start), .stop(stop),
        .frequency_control(freq0), .note_gate(gate0), .note_index(idx0),
        .note_strobe(strobe0), .busy(busy0), .done(done0)
    );

    note_sequencer #(
        .counter_width(8), .dur_width(12), .addr_width(4), .tick_div(TD), .gap_ticks(2)
    ) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
        .wr_duration(wr_duration), .length(length), .loop(loop), .start(start), .stop(stop),
        .frequency_control(freq2), .note_gate(gate2), .note_index(idx2),
        .note_strobe(strobe2), .busy(busy2), .done(done2)
    );

    task automatic check_out(input string name, input int k, input out_t act, input out_t want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s edge %0d: got f=%0d g=%0b i=%0d s=%0b b=%0b d=%0b, want f=%0d g=%0b i=%0d s=%0b b=%0b d=%0b",
                     name, k, act.freq, act.gate, act.idx, act.strobe, act.busy, act.done,
                     want.freq, want.gate, want.idx, want.strobe, want.busy, want.done);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic write_entry(input int a, input int p, input int d);
        wr_en       = 1'b1;
        wr_addr     = 4'(a);
        wr_period   = 8'(p);
        wr_duration = 12'(d);
        tb_per[a]   = p;
        tb_dur[a]   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Outputs from edge 'from' onward take value v (pulses cleared).
    task automatic fill(input int from, input out_t v);
        for (int k = from; k < MaxE; k++) begin
            mdl[k]        = v;
            mdl[k].strobe = 1'b0;
            mdl[k].done   = 1'b0;
        end
    endtask

    task automatic finish_at(input int e);
        fill(e, '0);
        if (e < MaxE) mdl[e].done = 1'b1;
    endtask

    // Timeline model. Edge 0 samples start; ticks fall on edges that are multiples of TD.
    task automatic build_model(input int gap, input int len, input bit lp, input int stop_e,
                               input int n);
        int   e, idx, skips, endt;
        out_t cur;
        for (int k = 0; k < MaxE; k++) mdl[k] = '0;
        if (len > 0) begin
            cur      = '0;
            cur.busy = 1'b1;
            fill(0, cur);
            idx   = 0;
            skips = 0;
            e     = 1;
            while (e < n) begin
                if (tb_dur[idx] == 0) begin
                    skips++;
                    if (skips == len || (idx == len - 1 && !lp)) begin
                        finish_at(e);
                        break;
                    end
                    idx     = (idx == len - 1) ? 0 : idx + 1;
                    cur.idx = 4'(idx);
                    fill(e, cur);
                    e++;
                end else begin
                    skips    = 0;
                    cur.freq = 8'(tb_per[idx]);
                    cur.gate = (tb_per[idx] != 0);
                    fill(e, cur);
                    mdl[e].strobe = 1'b1;
                    endt = (e / TD + tb_dur[idx]) * TD;
                    if (gap > 0) begin
                        cur.gate = 1'b0;
                        fill(endt, cur);
                        endt += gap * TD;
                    end
                    e = endt + 1;
                    if (idx == len - 1 && !lp) begin
                        finish_at(e);
                        break;
                    end
                    idx     = (idx == len - 1) ? 0 : idx + 1;
                    cur.idx = 4'(idx);
                    fill(e, cur);
                    e++;
                end
            end
        end
        if (stop_e >= 0) begin
            for (int k = stop_e; k < MaxE; k++) mdl[k] = '0;
        end
    endtask

    task automatic run_case(input string name, input int len, input bit lp, input int stop_e,
                            input int xstart, input int n,
                            output int s0, output int d0, output int s2, output int d2);
        build_model(0, len, lp, stop_e, n);
        exp0 = mdl;
        build_model(2, len, lp, stop_e, n);
        exp2 = mdl;
        s0 = 0; d0 = 0; s2 = 0; d2 = 0;
        for (int k = 0; k < n; k++) begin
            start  = (k == 0) || (k == xstart);
            stop   = (k == stop_e);
            length = 5'(len);
            loop   = lp;
            @(posedge clk);
            #1;
            start = 1'b0;
            stop  = 1'b0;
            check_out({name, "/g0"}, k, {freq0, gate0, idx0, strobe0, busy0, done0}, exp0[k]);
            check_out({name, "/g2"}, k, {freq2, gate2, idx2, strobe2, busy2, done2}, exp2[k]);
            s0 += int'(strobe0);
            d0 += int'(done0);
            s2 += int'(strobe2);
            d2 += int'(done2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_table(input int tab);
        case (tab)
            0: begin write_entry(0, 40, 3); write_entry(1, 0, 2);  write_entry(2, 20, 1); end
            1: begin write_entry(0, 40, 3); write_entry(1, 30, 0); write_entry(2, 20, 1); end
            default: begin
                write_entry(0, 40, 0); write_entry(1, 0, 0); write_entry(2, 20, 0);
            end
        endcase
    endtask

    initial begin
        vec_t vecs [6];
        int   s0, d0, s2, d2;
        int   len, stop_e;
        bit   lp;

        // tab, len, loop, stop edge, extra start edge, edges, strobes/done gap0, gap2
        vecs[0] = '{0, 3, 1'b0, -1,  5, 60, 3, 1, 3, 1};  // basic, start while playing
        vecs[1] = '{0, 3, 1'b1, 56, -1, 60, 7, 0, 4, 0};  // looping
        vecs[2] = '{1, 3, 1'b0, -1, -1, 40, 2, 1, 2, 1};  // entry 1 skipped
        vecs[3] = '{2, 3, 1'b1, -1, -1, 10, 0, 1, 0, 1};  // nothing playable
        vecs[4] = '{0, 3, 1'b0, 24, -1, 30, 3, 0, 2, 0};  // stop on final tick of last note
        vecs[5] = '{0, 0, 1'b0, -1, -1,  6, 0, 0, 0, 0};  // zero length ignored

        repeat (3) @(posedge clk);
        #1;
        check_out("reset/g0", 0, {freq0, gate0, idx0, strobe0, busy0, done0}, '0);
        check_out("reset/g2", 0, {freq2, gate2, idx2, strobe2, busy2, done2}, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_reset/g0", 0, {freq0, gate0, idx0, strobe0, busy0, done0}, '0);

        foreach (vecs[i]) begin
            load_table(vecs[i].tab);
            run_case($sformatf("vec%0d", i), vecs[i].len, vecs[i].lp, vecs[i].stop_e,
                     vecs[i].xstart, vecs[i].n, s0, d0, s2, d2);
            check_int($sformatf("vec%0d strobes g0", i), s0, vecs[i].s0);
            check_int($sformatf("vec%0d done g0", i), d0, vecs[i].d0);
            check_int($sformatf("vec%0d strobes g2", i), s2, vecs[i].s2);
            check_int($sformatf("vec%0d done g2", i), d2, vecs[i].d2);
        end

        // Asynchronous reset mid-note, off the clock edge.
        load_table(0);
        length = 5'd3;
        loop   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_int("pre_reset busy g0", int'(busy0), 1);
        check_int("pre_reset freq g2", int'(freq2), 40);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset/g0", 0, {freq0, gate0, idx0, strobe0, busy0, done0}, '0);
        check_out("async_reset/g2", 0, {freq2, gate2, idx2, strobe2, busy2, done2}, '0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_out("after_reset/g0", 0, {freq0, gate0, idx0, strobe0, busy0, done0}, '0);
            check_out("after_reset/g2", 0, {freq2, gate2, idx2, strobe2, busy2, done2}, '0);
        end

        // Randomized tables, lengths, loop and stop points.
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 8));
            lp  = 1'($urandom_range(0, 1));
            for (int a = 0; a < len; a++) begin
                write_entry(a, ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 255)),
                            ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 3)));
            end
            if (lp || ($urandom % 2 == 0)) stop_e = int'($urandom_range(2, MaxE - 6));
            else stop_e = -1;
            run_case($sformatf("rand%0d", r), len, lp, stop_e, -1, MaxE, s0, d0, s2, d2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
